// File: rtl/cnt_status_writer_pkg.sv
// Shared constants and types for the controller-region status writer.
// The word0 bit positions and the status snapshot layout are defined here.
package cnt_status_writer_pkg;

    localparam logic [7:0] ADDR_STATUS_BASE = 8'h40;
    localparam int         STATUS_WORDS     = 4;

    localparam int W0_BIT_VALID       = 0;
    localparam int W0_BIT_THERMO      = 1;
    localparam int W0_BIT_FORCE_FAN   = 2;
    localparam int W0_BIT_MOD_SEGMENT = 3;
    localparam int W0_BIT_STM_SEGMENT = 4;
    localparam int W0_BIT_STM_MODE    = 5;
    localparam int W0_BIT_SEQ_LSB     = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WRITE,
        ST_RELEASE
    } state_e;

    typedef struct packed {
        logic stmMode;
        logic stmSegment;
        logic modSegment;
        logic forceFan;
        logic thermo;
    } status_flags_t;

    typedef struct packed {
        status_flags_t flags;
        logic [14:0]   modIdx;
        logic [15:0]   stmIdx;
    } status_snap_t;

    // Builds status word idx from a captured snapshot and the sequence count.
    function automatic logic [15:0] statusWord(input status_snap_t snap,
                                               input logic [15:0]  seq,
                                               input logic [1:0]   idx);
        logic [15:0] word;
        word = '0;
        case (idx)
            2'd0: begin
                word[W0_BIT_VALID]       = 1'b1;
                word[W0_BIT_THERMO]      = snap.flags.thermo;
                word[W0_BIT_FORCE_FAN]   = snap.flags.forceFan;
                word[W0_BIT_MOD_SEGMENT] = snap.flags.modSegment;
                word[W0_BIT_STM_SEGMENT] = snap.flags.stmSegment;
                word[W0_BIT_STM_MODE]    = snap.flags.stmMode;
                word[W0_BIT_SEQ_LSB]     = seq[0];
            end
            2'd1:    word = {1'b0, snap.modIdx};
            2'd2:    word = snap.stmIdx;
            default: word = seq;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/cnt_status_writer.sv
// Writes a four-word status block into the controller BRAM region whenever a
// flag changes or the refresh period expires, arbitrating via REQ/GNT.
module cnt_status_writer
    import cnt_status_writer_pkg::*;
#(
    parameter int REFRESH_CYCLES = 20480
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        THERMO,
    input  logic        FORCE_FAN,
    input  logic        MOD_SEGMENT,
    input  logic        STM_SEGMENT,
    input  logic        STM_MODE,
    input  logic [14:0] MOD_IDX,
    input  logic [15:0] STM_IDX,
    output logic        REQ,
    input  logic        GNT,
    output logic        WE,
    output logic [7:0]  ADDR,
    output logic [15:0] DIN
);

    localparam int             CW           = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0]  REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [1:0]     LAST_WORD    = 2'(STATUS_WORDS - 1);

    state_e        state_q, state_d;
    logic [1:0]    wordIdx_q, wordIdx_d;
    logic [CW-1:0] refresh_q;
    logic [15:0]   seq_q;
    status_snap_t  snap_q;
    status_flags_t lastFlags_q;
    logic          req_q;
    logic [7:0]    addr_q;
    logic [15:0]   din_q;

    status_flags_t flagsNow;
    status_snap_t  snapNow;
    logic          trigger;

    always_comb begin
        flagsNow = '{stmMode:    STM_MODE,
                     stmSegment: STM_SEGMENT,
                     modSegment: MOD_SEGMENT,
                     forceFan:   FORCE_FAN,
                     thermo:     THERMO};
        snapNow  = '{flags: flagsNow, modIdx: MOD_IDX, stmIdx: STM_IDX};
        trigger  = (flagsNow != lastFlags_q) || (refresh_q == REFRESH_LAST);
    end

    // Word index only advances on a granted write, so a lost grant resumes in place.
    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d   = ST_REQUEST;
                    wordIdx_d = 2'd0;
                end
            end
            ST_REQUEST: begin
                if (GNT) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (GNT) begin
                    if (wordIdx_q == LAST_WORD) begin
                        state_d = ST_RELEASE;
                    end else begin
                        wordIdx_d = wordIdx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        WE   = (state_q == ST_WRITE) && GNT;
        REQ  = req_q;
        ADDR = addr_q;
        DIN  = din_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            wordIdx_q   <= 2'd0;
            refresh_q   <= '0;
            seq_q       <= 16'd0;
            snap_q      <= '0;
            lastFlags_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= 8'd0;
            din_q       <= 16'd0;
        end else begin
            state_q   <= state_d;
            wordIdx_q <= wordIdx_d;
            req_q     <= (state_d == ST_REQUEST) || (state_d == ST_WRITE);

            if ((state_q == ST_IDLE) && (state_d == ST_REQUEST)) begin
                snap_q <= snapNow;
            end

            // Refresh period restarts after each completed burst.
            if (state_q == ST_RELEASE) begin
                seq_q       <= seq_q + 16'd1;
                lastFlags_q <= snap_q.flags;
                refresh_q   <= '0;
            end else if (refresh_q != REFRESH_LAST) begin
                refresh_q <= refresh_q + 1'b1;
            end

            if (state_d == ST_WRITE) begin
                addr_q <= ADDR_STATUS_BASE + {6'd0, wordIdx_d};
                din_q  <= statusWord(snap_q, seq_q, wordIdx_d);
            end
        end
    end

endmodule
